// File: rtl/sa_cache_fsm.sv
// sa_cache_fsm: 1- or 2-way set-associative, write-back, write-allocate cache controller.
// Sits between a CPU word port and a line-wide memory port. Tag, data, valid, dirty and LRU
// state are internal flops. Define CACHE_STATS_EN to build the hit/miss/write-back counters;
// without it the stat outputs are tied to zero.
module sa_cache_fsm #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SETS   = 256,
  parameter int unsigned WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_data,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic [DATA_W-1:0] cpu_res_data,
  output logic              cpu_res_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [LINE_W-1:0] mem_data_data,
  input  logic              mem_data_ready,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbacks
);

  localparam int unsigned OFF   = $clog2(LINE_W / 8);
  localparam int unsigned WOFF  = $clog2(DATA_W / 8);
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX - OFF;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("sa_cache_fsm: WAYS must be 1 or 2");
  end

  typedef enum logic [1:0] {StIdle, StCompare, StWriteBack, StAllocate} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic              victim_q;     // way chosen for eviction/fill on the current miss
  logic              recompare_q;  // COMPARE after a fill: not a first-pass lookup
  logic              gap_q;        // one idle cycle on the memory port after a write-back
  logic              res_ready_q;
  logic [DATA_W-1:0] res_data_q;

  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];
  logic              lru_mem   [SETS];  // way to evict next when both are valid

  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF-1:0]    word;
  int unsigned       word_lsb;
  logic [WAYS-1:0]   valid_set, dirty_set, hit_vec;
  logic              hit, hit_way, victim;
  logic [LINE_W-1:0] hit_line, merged_line;
  logic [DATA_W-1:0] hit_word;
  logic              accept, wr_hit_en, fill_en, wb_done;

  assign idx       = addr_q[OFF +: IDX];
  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign word      = addr_q[OFF-1:0] >> WOFF;
  assign word_lsb  = 32'(word) * DATA_W;
  assign valid_set = valid_mem[idx];
  assign dirty_set = dirty_mem[idx];

  for (genvar w = 0; w < WAYS; w++) begin : g_hit
    assign hit_vec[w] = valid_set[w] && (tag_mem[w][idx] == tag);
  end

  assign hit     = |hit_vec;
  // With two ways a hit that is not in way 0 must be in way 1.
  assign hit_way = (WAYS == 2) ? !hit_vec[0] : 1'b0;
  // Lowest invalid way first, otherwise the LRU way.
  assign victim  = (WAYS == 1)            ? 1'b0 :
                   !valid_set[0]          ? 1'b0 :
                   !valid_set[WAYS-1]     ? 1'b1 : lru_mem[idx];

  assign hit_line = data_mem[hit_way][idx];
  assign hit_word = hit_line[word_lsb +: DATA_W];

  // Hit line with the latched write word merged in.
  always_comb begin
    merged_line = hit_line;
    merged_line[word_lsb +: DATA_W] = wdata_q;
  end

  assign accept    = (state_q == StIdle) && cpu_req_valid && !res_ready_q;
  assign wr_hit_en = (state_q == StCompare) && hit && rw_q;
  assign fill_en   = (state_q == StAllocate) && !gap_q && mem_data_ready;
  assign wb_done   = (state_q == StWriteBack) && mem_data_ready;

  // Next-state logic and memory request outputs.
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCompare;
      end
      StCompare: begin
        if (hit) begin
          state_d = StIdle;
        end else if (valid_set[victim] && dirty_set[victim]) begin
          state_d = StWriteBack;
        end else begin
          state_d = StAllocate;
        end
      end
      StWriteBack: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_mem[victim_q][idx], idx, {OFF{1'b0}}};
        mem_req_data  = data_mem[victim_q][idx];
        if (mem_data_ready) state_d = StAllocate;
      end
      StAllocate: begin
        mem_req_valid = !gap_q;
        mem_req_addr  = {tag, idx, {OFF{1'b0}}};
        if (fill_en) state_d = StCompare;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, request latch, registered response and per-set status bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      victim_q    <= 1'b0;
      recompare_q <= 1'b0;
      gap_q       <= 1'b0;
      res_ready_q <= 1'b0;
      res_data_q  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        lru_mem[s]   <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      res_ready_q <= 1'b0;
      gap_q       <= wb_done;
      if (accept) begin
        addr_q      <= cpu_req_addr;
        wdata_q     <= cpu_req_data;
        rw_q        <= cpu_req_rw;
        recompare_q <= 1'b0;
      end
      if (state_q == StCompare) begin
        if (hit) begin
          res_ready_q  <= 1'b1;
          res_data_q   <= rw_q ? wdata_q : hit_word;
          lru_mem[idx] <= (WAYS == 2) ? ~hit_way : 1'b0;
          if (rw_q) dirty_mem[idx][hit_way] <= 1'b1;
        end else begin
          victim_q <= victim;
        end
      end
      if (fill_en) begin
        valid_mem[idx][victim_q] <= 1'b1;
        dirty_mem[idx][victim_q] <= 1'b0;
        recompare_q              <= 1'b1;
      end
    end
  end

  // Line and tag storage: fills from memory, word merges on write hits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        data_mem[victim_q][idx] <= mem_data_data;
        tag_mem[victim_q][idx]  <= tag;
      end else if (wr_hit_en) begin
        data_mem[hit_way][idx] <= merged_line;
      end
    end
  end

  assign cpu_res_ready = res_ready_q;
  assign cpu_res_data  = res_data_q;

  // Sub-word address bits select nothing inside a word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[WOFF-1:0];

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q, wbacks_q;

  // Saturating counters; the re-compare after a fill is not a new lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbacks_q <= '0;
    end else begin
      if (state_q == StCompare && !recompare_q) begin
        if (hit && hits_q != '1) hits_q <= hits_q + 32'd1;
        if (!hit && misses_q != '1) misses_q <= misses_q + 32'd1;
      end
      if (wb_done && wbacks_q != '1) wbacks_q <= wbacks_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbacks = wbacks_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_wbacks = '0;
`endif

endmodule

// File: tb/tb_sa_cache_fsm.sv
// Self-checking bench for sa_cache_fsm (default parameters). Expected values come from a
// line-level reference model: architectural contents, resident lines with last-use stamps,
// and dirty flags.
module tb_sa_cache_fsm;

  localparam int WAYS = 2;
`ifdef CACHE_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [31:0]  cpu_req_addr, cpu_req_data, cpu_res_data;
  logic         cpu_req_rw, cpu_req_valid, cpu_res_ready;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data, mem_data_data;
  logic         mem_req_rw, mem_req_valid, mem_data_ready;
  logic [31:0]  stat_hits, stat_misses, stat_wbacks;

  sa_cache_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_data  (cpu_req_data),
    .cpu_req_rw    (cpu_req_rw),
    .cpu_req_valid (cpu_req_valid),
    .cpu_res_data  (cpu_res_data),
    .cpu_res_ready (cpu_res_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_rw    (mem_req_rw),
    .mem_req_valid (mem_req_valid),
    .mem_data_data (mem_data_data),
    .mem_data_ready(mem_data_ready),
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses),
    .stat_wbacks   (stat_wbacks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [127:0] mem_model [logic [31:0]];
  logic [127:0] truth     [logic [31:0]];
  int unsigned  resident  [logic [31:0]];
  bit           dirty_m   [logic [31:0]];
  int unsigned  tick = 0;
  int           m_hits = 0, m_misses = 0, m_wbs = 0;

  // Observations and model expectations of the latest access.
  logic [31:0]  obs_rd, obs_wb_a, obs_fill_a;
  logic [127:0] obs_wb_d;
  int           obs_cyc, obs_nwb, obs_nfill;
  bit           obs_stable, obs_gap, obs_pulse, obs_to;
  bit           exp_hit, exp_wb;
  logic [31:0]  exp_wb_a, exp_rd;
  logic [127:0] exp_wb_d;

  function automatic logic [127:0] line_default(input logic [31:0] la);
    return {la ^ 32'h3333_0003, la ^ 32'h2222_0002, la ^ 32'h1111_0001, la ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] la);
    if (truth.exists(la)) return truth[la];
    if (mem_model.exists(la)) return mem_model[la];
    return line_default(la);
  endfunction

  // Reset loses cached dirty data: contents fall back to what memory holds.
  function automatic void model_reset();
    truth.delete();
    resident.delete();
    dirty_m.delete();
    m_hits = 0;
    m_misses = 0;
    m_wbs = 0;
  endfunction

  function automatic void model_step(input logic [31:0] a, input logic rw, input logic [31:0] wd);
    logic [31:0]  la, v, kk;
    logic [127:0] l;
    int           cnt, w;
    int unsigned  best;
    la = {a[31:4], 4'h0};
    w = int'(a[3:2]);
    exp_hit = resident.exists(la);
    exp_wb = 1'b0;
    exp_wb_a = '0;
    exp_wb_d = '0;
    if (exp_hit) begin
      m_hits++;
    end else begin
      m_misses++;
      cnt = 0;
      best = 32'hFFFF_FFFF;
      v = '0;
      foreach (resident[k]) begin
        kk = k;
        if (kk[11:4] == la[11:4]) begin
          cnt++;
          if (resident[k] < best) begin
            best = resident[k];
            v = kk;
          end
        end
      end
      if (cnt >= WAYS) begin
        if (dirty_m.exists(v)) begin
          exp_wb = 1'b1;
          exp_wb_a = v;
          exp_wb_d = line_of(v);
          dirty_m.delete(v);
          m_wbs++;
        end
        resident.delete(v);
      end
    end
    tick++;
    resident[la] = tick;
    l = line_of(la);
    if (rw) begin
      l[w*32 +: 32] = wd;
      truth[la] = l;
      dirty_m[la] = 1'b1;
    end
    exp_rd = l[w*32 +: 32];
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    mem_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // One CPU transaction plus a memory responder answering after 'lat' waiting cycles.
  task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                        input int lat);
    int          wait_n;
    bit          holding, done;
    logic [31:0] h_addr;
    logic        h_rw;
    logic [127:0] h_data;
    model_step(a, rw, wd);
    obs_rd = '0; obs_cyc = 0; obs_nwb = 0; obs_nfill = 0; obs_wb_a = '0; obs_wb_d = '0;
    obs_fill_a = '0; obs_stable = 1'b1; obs_gap = 1'b1; obs_to = 1'b0;
    h_addr = '0; h_rw = 1'b0; h_data = '0;
    cpu_req_addr = a;
    cpu_req_rw = rw;
    cpu_req_data = wd;
    cpu_req_valid = 1'b1;
    wait_n = 0;
    holding = 1'b0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      obs_cyc++;
      if (mem_data_ready) begin
        mem_data_ready = 1'b0;
        if (mem_req_valid) obs_gap = 1'b0;
        holding = 1'b0;
      end else if (mem_req_valid) begin
        if (!holding) begin
          holding = 1'b1;
          wait_n = 0;
          h_addr = mem_req_addr;
          h_rw = mem_req_rw;
          h_data = mem_req_data;
        end else if (mem_req_addr !== h_addr || mem_req_rw !== h_rw || mem_req_data !== h_data) begin
          obs_stable = 1'b0;
        end
        if (cpu_res_ready) obs_stable = 1'b0;
        if (wait_n >= lat) begin
          mem_data_ready = 1'b1;
          if (mem_req_rw) begin
            obs_nwb++;
            obs_wb_a = mem_req_addr;
            obs_wb_d = mem_req_data;
            mem_model[mem_req_addr] = mem_req_data;
          end else begin
            obs_nfill++;
            obs_fill_a = mem_req_addr;
            mem_data_data = mem_model.exists(mem_req_addr) ? mem_model[mem_req_addr]
                                                           : line_default(mem_req_addr);
          end
        end
        wait_n++;
      end
      if (cpu_res_ready) begin
        obs_rd = cpu_res_data;
        cpu_req_valid = 1'b0;
        done = 1'b1;
      end else if (obs_cyc > 300) begin
        obs_to = 1'b1;
        cpu_req_valid = 1'b0;
        done = 1'b1;
      end
    end
    mem_data_ready = 1'b0;
    @(negedge clk);
    obs_pulse = (cpu_res_ready === 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (cpu_res_ready !== 1'b0) $display("FAIL reset_res_ready: got %b want 0", cpu_res_ready); else n_pass++;
    n_checks++; if (cpu_res_data !== 32'h0) $display("FAIL reset_res_data: got %h want 0", cpu_res_data); else n_pass++;
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); else n_pass++;
    n_checks++; if (mem_req_rw !== 1'b0) $display("FAIL reset_mem_rw: got %b want 0", mem_req_rw); else n_pass++;
    n_checks++; if (mem_req_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_req_addr); else n_pass++;
    n_checks++; if (mem_req_data !== 128'h0) $display("FAIL reset_mem_data: got %h want 0", mem_req_data); else n_pass++;
    n_checks++;
    if ({stat_hits, stat_misses, stat_wbacks} !== 96'h0)
      $display("FAIL reset_stats: got %h/%h/%h want 0/0/0", stat_hits, stat_misses, stat_wbacks);
    else n_pass++;
  endtask

  task automatic test_fill_hit();
    mem_model[32'h0000_1000] = 128'h44444444_33333333_22222222_11111111;
    access(32'h0000_1004, 1'b0, 32'h0, 2);
    n_checks++; if (obs_to !== 1'b0) $display("FAIL fill_timeout: got %b want 0", obs_to); else n_pass++;
    n_checks++; if (obs_nfill !== 1 || obs_fill_a !== 32'h0000_1000)
      $display("FAIL fill_req: got %0d fills addr %h want 1 at 00001000", obs_nfill, obs_fill_a); else n_pass++;
    n_checks++; if (obs_nwb !== 0) $display("FAIL fill_no_wb: got %0d want 0", obs_nwb); else n_pass++;
    n_checks++; if (obs_rd !== 32'h2222_2222) $display("FAIL fill_data: got %h want 22222222", obs_rd); else n_pass++;
    n_checks++; if (obs_pulse !== 1'b1) $display("FAIL fill_pulse: got %b want 1", obs_pulse); else n_pass++;
    access(32'h0000_1004, 1'b0, 32'h0, 2);
    n_checks++; if (obs_nfill + obs_nwb !== 0) $display("FAIL rehit_mem: got %0d reqs want 0", obs_nfill + obs_nwb); else n_pass++;
    n_checks++; if (obs_cyc !== 2) $display("FAIL rehit_latency: got %0d want 2", obs_cyc); else n_pass++;
    n_checks++; if (obs_rd !== 32'h2222_2222) $display("FAIL rehit_data: got %h want 22222222", obs_rd); else n_pass++;
    n_checks++; if (obs_pulse !== 1'b1) $display("FAIL rehit_pulse: got %b want 1", obs_pulse); else n_pass++;
  endtask

  task automatic test_write_hit();
    access(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 1);
    n_checks++; if (obs_nfill + obs_nwb !== 0) $display("FAIL wrhit_mem: got %0d reqs want 0", obs_nfill + obs_nwb); else n_pass++;
    n_checks++; if (obs_cyc !== 2) $display("FAIL wrhit_latency: got %0d want 2", obs_cyc); else n_pass++;
    access(32'h0000_1008, 1'b0, 32'h0, 1);
    n_checks++; if (obs_rd !== 32'hDEAD_BEEF) $display("FAIL wrhit_readback: got %h want deadbeef", obs_rd); else n_pass++;
    n_checks++; if (obs_cyc !== 2) $display("FAIL wrhit_read_latency: got %0d want 2", obs_cyc); else n_pass++;
  endtask

  task automatic test_eviction();
    logic [127:0] wbd;
    access(32'h0001_1000, 1'b0, 32'h0, 1);
    n_checks++; if (obs_nfill !== 1 || obs_fill_a !== 32'h0001_1000)
      $display("FAIL way1_fill: got %0d fills addr %h want 1 at 00011000", obs_nfill, obs_fill_a); else n_pass++;
    n_checks++; if (obs_nwb !== 0) $display("FAIL way1_no_wb: got %0d want 0", obs_nwb); else n_pass++;
    n_checks++; if (obs_rd !== exp_rd) $display("FAIL way1_data: got %h want %h", obs_rd, exp_rd); else n_pass++;
    access(32'h0002_1000, 1'b0, 32'h0, 2);
    wbd = obs_wb_d;
    n_checks++; if (obs_nwb !== 1 || obs_wb_a !== 32'h0000_1000)
      $display("FAIL evict_wb: got %0d wbs addr %h want 1 at 00001000", obs_nwb, obs_wb_a); else n_pass++;
    n_checks++; if (wbd[95:64] !== 32'hDEAD_BEEF) $display("FAIL evict_wb_word2: got %h want deadbeef", wbd[95:64]); else n_pass++;
    n_checks++; if (obs_wb_d !== exp_wb_d) $display("FAIL evict_wb_line: got %h want %h", obs_wb_d, exp_wb_d); else n_pass++;
    n_checks++; if (obs_nfill !== 1 || obs_fill_a !== 32'h0002_1000)
      $display("FAIL evict_fill: got %0d fills addr %h want 1 at 00021000", obs_nfill, obs_fill_a); else n_pass++;
    n_checks++; if (obs_gap !== 1'b1) $display("FAIL evict_gap: got %b want 1", obs_gap); else n_pass++;
    n_checks++; if (obs_rd !== exp_rd) $display("FAIL evict_data: got %h want %h", obs_rd, exp_rd); else n_pass++;
  endtask

  task automatic test_stats(input int eh, input int em, input int ew);
    logic [31:0] xh, xm, xw;
    xh = StatsOn ? 32'(eh) : 32'h0;
    xm = StatsOn ? 32'(em) : 32'h0;
    xw = StatsOn ? 32'(ew) : 32'h0;
    n_checks++; if (stat_hits !== xh) $display("FAIL stat_hits: got %0d want %0d", stat_hits, xh); else n_pass++;
    n_checks++; if (stat_misses !== xm) $display("FAIL stat_misses: got %0d want %0d", stat_misses, xm); else n_pass++;
    n_checks++; if (stat_wbacks !== xw) $display("FAIL stat_wbacks: got %0d want %0d", stat_wbacks, xw); else n_pass++;
  endtask

  task automatic test_stall();
    bit quiet;
    access(32'h0003_0040, 1'b0, 32'h0, 20);
    n_checks++; if (obs_stable !== 1'b1) $display("FAIL stall_stable: got %b want 1", obs_stable); else n_pass++;
    n_checks++; if (obs_cyc <= 20) $display("FAIL stall_latency: got %0d want >20", obs_cyc); else n_pass++;
    n_checks++; if (obs_rd !== exp_rd) $display("FAIL stall_data: got %h want %h", obs_rd, exp_rd); else n_pass++;
    // Stray memory completion while idle.
    mem_data_data = {4{32'hBAD0_BAD0}};
    mem_data_ready = 1'b1;
    @(negedge clk);
    mem_data_ready = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_req_valid !== 1'b0 || cpu_res_ready !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (quiet !== 1'b1) $display("FAIL idle_pulse_quiet: got %b want 1", quiet); else n_pass++;
    access(32'h0003_0044, 1'b0, 32'h0, 1);
    n_checks++; if (obs_cyc !== 2 || obs_nfill !== 0)
      $display("FAIL idle_pulse_hit: got cyc %0d fills %0d want 2/0", obs_cyc, obs_nfill); else n_pass++;
    n_checks++; if (obs_rd !== exp_rd) $display("FAIL idle_pulse_data: got %h want %h", obs_rd, exp_rd); else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit seen;
    cpu_req_addr = 32'h0000_1000;
    cpu_req_rw = 1'b0;
    cpu_req_data = '0;
    cpu_req_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL rstmid_req_seen: got %b want 1", seen); else n_pass++;
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rstmid_drop: got %b want 0", mem_req_valid); else n_pass++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    access(32'h0000_1000, 1'b0, 32'h0, 1);
    n_checks++; if (obs_nfill !== 1 || obs_fill_a !== 32'h0000_1000)
      $display("FAIL rstmid_remiss: got %0d fills addr %h want 1 at 00001000", obs_nfill, obs_fill_a); else n_pass++;
    n_checks++; if (obs_rd !== 32'h1111_1111) $display("FAIL rstmid_data: got %h want 11111111", obs_rd); else n_pass++;
    access(32'h0000_1008, 1'b0, 32'h0, 1);
    n_checks++; if (obs_rd !== 32'hDEAD_BEEF) $display("FAIL rstmid_wb_kept: got %h want deadbeef", obs_rd); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic        rw;
    for (int it = 0; it < 60; it++) begin
      a  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 1)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      access(a, rw, wd, int'($urandom_range(0, 3)));
      n_checks++; if (obs_to !== 1'b0) $display("FAIL rnd%0d_timeout: got %b want 0", it, obs_to); else n_pass++;
      n_checks++; if (obs_nfill !== (exp_hit ? 0 : 1))
        $display("FAIL rnd%0d_fill: addr %h got %0d fills want %0d", it, a, obs_nfill, exp_hit ? 0 : 1); else n_pass++;
      n_checks++; if (obs_nwb !== int'(exp_wb))
        $display("FAIL rnd%0d_wb: addr %h got %0d wbs want %0d", it, a, obs_nwb, exp_wb); else n_pass++;
      if (exp_wb) begin
        n_checks++; if (obs_wb_a !== exp_wb_a || obs_wb_d !== exp_wb_d)
          $display("FAIL rnd%0d_wb_line: got %h:%h want %h:%h", it, obs_wb_a, obs_wb_d, exp_wb_a, exp_wb_d); else n_pass++;
      end
      if (exp_hit) begin
        n_checks++; if (obs_cyc !== 2) $display("FAIL rnd%0d_hit_latency: got %0d want 2", it, obs_cyc); else n_pass++;
      end
      if (!rw) begin
        n_checks++; if (obs_rd !== exp_rd) $display("FAIL rnd%0d_data: addr %h got %h want %h", it, a, obs_rd, exp_rd); else n_pass++;
      end
      n_checks++; if (obs_pulse !== 1'b1 || obs_gap !== 1'b1)
        $display("FAIL rnd%0d_handshake: pulse %b gap %b want 1 1", it, obs_pulse, obs_gap); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req_addr = '0;
    cpu_req_data = '0;
    cpu_req_rw = 1'b0;
    cpu_req_valid = 1'b0;
    mem_data_data = '0;
    mem_data_ready = 1'b0;
    test_reset();
    test_fill_hit();
    test_write_hit();
    test_eviction();
    test_stats(3, 3, 1);
    test_stall();
    test_rst_mid();
    test_random();
    test_stats(m_hits, m_misses, m_wbs);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
